smem_request_unit: RTL and testbench
====================================

# smem_request_unit

Downstream execution stage for scalar memory loads. Accepts a fully decoded `smem_inst_t` from the SMEM decoder and reads the base address and offset SGPRs. It then issues one dword request per loaded dword to the Scalar Data Cache and writes each returned dword into consecutive SGPRs starting at `sdata`. One instruction is in flight at a time; back-pressure to the decoder is through `inst_ready`.

## Interface
- No parameters; widths come from `common_pkg`.
- `clk` in 1: clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `smem_inst_in` in `smem_inst_t`: fields used are sbase[5:0], sdata[6:0], dlc, glc, op[7:0], offset[20:0], soffset[6:0].
- `inst_valid` in 1: decoder output valid.
- `inst_ready` out 1: high only in IDLE. Transfer occurs when valid & ready.
- `sgpr_rd_addr` out 7: SGPR read index. The read is registered: data appears the cycle after the address.
- `sgpr_rd_data` in 32: SGPR read data.
- `req_valid` out 1, `req_ready` in 1: cache request handshake.
- `req_addr` out 64: byte address; bits [1:0] are always 0.
- `req_glc`, `req_dlc` out 1: copied from the instruction.
- `resp_valid` in 1, `resp_data` in 32: in-order dword responses. There is no ready signal; the unit always sinks responses.
- `sgpr_wr_en` out 1, `sgpr_wr_addr` out 7, `sgpr_wr_data` out 32: SGPR write port.
- `done` out 1: one-cycle pulse when the last dword is written.
- `err` out 1: one-cycle pulse on an illegal op or a misaligned destination (see Configuration).

## Operation
- **Op decode**
  - op 0..4 give N = 1, 2, 4, 8, 16 dwords (S_LOAD_DWORD×N).
  - op > 4 is illegal: `err` pulses, no request is issued, and the unit returns to IDLE.
- **States**: IDLE, RD_LO, RD_HI, RD_SOFF, CALC, ISSUE, DRAIN.
- **IDLE**
  - `inst_ready`=1. On transfer, latch the instruction and go to RD_LO.
- **RD_LO**
  - `sgpr_rd_addr`={sbase,1'b0}. Go to RD_HI.
- **RD_HI**
  - `sgpr_rd_addr`={sbase,1'b1}.
  - Capture base[31:0]. Go to RD_SOFF.
- **RD_SOFF**
  - `sgpr_rd_addr`=soffset.
  - Capture base[63:32]. Go to CALC.
- **CALC**
  - Capture the soffset value. If soffset==`SMEM_SOFFSET_NULL` (7'd125), substitute 0.
  - addr = (base + sext64(offset) + zext64(soffval)) & ~64'h3, computed modulo 2^64.
  - Go to ISSUE, or to IDLE with `err` if illegal.
- **ISSUE**
  - Present `req_addr` = addr + 4·issue_cnt, with `req_valid`=1.
  - issue_cnt increments on req_valid & req_ready.
  - Go to DRAIN on the handshake of request N-1.
- **DRAIN**
  - Wait until resp_cnt reaches N.
  - `done` pulses in the cycle the last write is issued; the next state is IDLE.
- **Responses**
  - Accepted in ISSUE and DRAIN, concurrently with issuing.
  - Each `resp_valid` drives the same-cycle combinational `sgpr_wr_en`=1, `sgpr_wr_addr`=sdata+resp_cnt (7-bit wrap), `sgpr_wr_data`=resp_data, and increments resp_cnt.
  - A response in any other state is dropped.
- **Counters**: issue_cnt and resp_cnt are 5 bits (0..16), cleared on IDLE exit.
- **Address wrap**: the per-dword address increments wrap modulo 2^64; no fault is raised.

## Timing
- Reset values:
  - `inst_ready`=1, `req_valid`=0, `req_addr`=0, `req_glc`=0, `req_dlc`=0.
  - `sgpr_rd_addr`=0, `sgpr_wr_en`=0, `sgpr_wr_addr`=0, `sgpr_wr_data`=0.
  - `done`=0, `err`=0; state IDLE; counters 0.
- Latency: with the transfer in cycle T, the first `req_valid` is asserted in T+5 (RD_LO=T+1, RD_HI=T+2, RD_SOFF=T+3, CALC=T+4).
- `req_valid` stays high and `req_addr` stays stable until accepted.
- A response may arrive in the same cycle as a request handshake; both counters update independently.
- A response may not precede its request. The cache guarantees this; the bench checks it.
- `done` and `inst_ready` are never high in the same cycle. The next transfer is at the earliest the cycle after `done`.
- Reset asserted mid-operation forces IDLE next cycle; responses still in flight from the aborted instruction are dropped.

## Configuration
- `SMEM_SDATA_ALIGN_CHECK_EN` defined:
  - In CALC, if sdata is not aligned to min(N,4) dwords, `err` pulses.
  - No request or write occurs, and the unit returns to IDLE.
- Undefined: alignment is not checked; `err` comes only from an illegal op.

## Structure
- `common_pkg` additions:
  - `SMEM_SOFFSET_NULL` (7'd125).
  - `smem_req_state_t` enum.
  - Function `smem_op_dwords(op)`, which returns the 5-bit N, or 0 for illegal.
- One sub-module, `smem_addr_calc`: combinational base + offset + soffset, the 64-bit dword-aligned sum. The FSM and counters stay in `smem_request_unit`.

## Test plan
- **Single dword**: S_LOAD_DWORD with sbase=2, SGPR4=32'h1000, SGPR5=0, offset=21'h10, soffset=125, `req_ready`=1 → one request with addr 64'h1010 at T+5; response 32'hDEAD writes SGPR[sdata]; `done` pulses.
- **16-dword load with back-pressure**: sdata=16, soffset SGPR value 8, `req_ready` toggling each cycle → 16 requests at addresses base+8+4i; writes to SGPR16..31 in order; `done` after the 16th write.
- **Negative offset**: offset=21'h1FFFFC (−4), base=64'h0 → addr=64'hFFFF_FFFF_FFFF_FFFC; the second dword wraps to 64'h0.
- **Illegal op**: op=8'h09 → `err` pulse at T+4, no `req_valid`, `inst_ready` back to 1.
- **Reset mid-DRAIN**: N=8, reset after 3 responses, then 5 stray responses → no writes after reset, state IDLE, all outputs at reset values.
- **With `SMEM_SDATA_ALIGN_CHECK_EN`**: op=2 (N=4), sdata=6 → `err`, no requests. Without the macro, the same stimulus → 4 writes to SGPR6..9.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and helpers for the scalar memory path: the decoded SMEM
// instruction, the request-unit state encoding and the op-to-dword-count map.
package common_pkg;

  typedef struct packed {
    logic [5:0]  sbase;
    logic [6:0]  sdata;
    logic        dlc;
    logic        glc;
    logic [7:0]  op;
    logic [20:0] offset;
    logic [6:0]  soffset;
  } smem_inst_t;

  // soffset encoding that means "no SGPR offset": contributes zero.
  localparam logic [6:0] SMEM_SOFFSET_NULL = 7'd125;

  typedef enum logic [2:0] {
    SMEM_IDLE,
    SMEM_RD_LO,
    SMEM_RD_HI,
    SMEM_RD_SOFF,
    SMEM_CALC,
    SMEM_ISSUE,
    SMEM_DRAIN
  } smem_req_state_t;

  // Number of dwords moved by an S_LOAD_DWORDxN op; 0 flags an illegal op.
  function automatic logic [4:0] smem_op_dwords(input logic [7:0] op);
    case (op)
      8'd0:    return 5'd1;
      8'd1:    return 5'd2;
      8'd2:    return 5'd4;
      8'd3:    return 5'd8;
      8'd4:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/smem_addr_calc.sv
// Scalar load address: base + sign-extended immediate offset + SGPR offset,
// taken modulo 2^64 and forced to dword alignment.
module smem_addr_calc (
  input  logic [63:0] base_i,
  input  logic [20:0] offset_i,
  input  logic [31:0] soff_i,
  output logic [63:0] addr_o
);

  logic [63:0] sum;

  // Full 64-bit sum; the low two bits are cleared rather than trapped.
  always_comb begin
    sum    = base_i + {{43{offset_i[20]}}, offset_i} + {32'd0, soff_i};
    addr_o = sum & ~64'h3;
  end

endmodule

// File: rtl/smem_request_unit.sv
// Scalar memory load execution stage: fetches base/offset SGPRs, issues one
// dword request per loaded dword and writes responses back to SGPRs in order.
// Optional build macro: SMEM_SDATA_ALIGN_CHECK_EN rejects destinations that
// are not aligned to min(N,4) dwords.
module smem_request_unit
  import common_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  smem_inst_t       smem_inst_in,
  input  logic             inst_valid,
  output logic             inst_ready,
  output logic [6:0]       sgpr_rd_addr,
  input  logic [31:0]      sgpr_rd_data,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [63:0]      req_addr,
  output logic             req_glc,
  output logic             req_dlc,
  input  logic             resp_valid,
  input  logic [31:0]      resp_data,
  output logic             sgpr_wr_en,
  output logic [6:0]       sgpr_wr_addr,
  output logic [31:0]      sgpr_wr_data,
  output logic             done,
  output logic             err
);

  smem_req_state_t state_q;
  smem_inst_t      inst_q;
  logic [63:0]     base_q;
  logic [6:0]      rd_addr_q;
  logic            req_valid_q;
  logic [63:0]     req_addr_q;
  logic [4:0]      issue_cnt_q;
  logic [4:0]      resp_cnt_q;

  logic [4:0]      n_dwords;
  logic [31:0]     soff_val;
  logic [63:0]     calc_addr;
  logic            misalign;
  logic            calc_err;
  logic            resp_take;
  logic            req_hs;
  logic            last_issue;
  logic            last_resp;

  smem_addr_calc u_addr_calc (
    .base_i   (base_q),
    .offset_i (inst_q.offset),
    .soff_i   (soff_val),
    .addr_o   (calc_addr)
  );

  // Decode of the latched instruction and the handshake/terminal conditions.
  // NOTE: every signal gets a value before any branch so no latch is inferred.
  always_comb begin
    n_dwords = smem_op_dwords(inst_q.op);
    soff_val = (inst_q.soffset == SMEM_SOFFSET_NULL) ? 32'd0 : sgpr_rd_data;
    misalign = 1'b0;
`ifdef SMEM_SDATA_ALIGN_CHECK_EN
    if (n_dwords == 5'd2)
      misalign = inst_q.sdata[0];
    else if (n_dwords >= 5'd4)
      misalign = |inst_q.sdata[1:0];
`endif
    calc_err   = !reset && (state_q == SMEM_CALC) && ((n_dwords == 5'd0) || misalign);
    resp_take  = !reset && resp_valid && ((state_q == SMEM_ISSUE) || (state_q == SMEM_DRAIN));
    req_hs     = req_valid_q && req_ready;
    last_issue = req_hs && ((issue_cnt_q + 5'd1) == n_dwords);
    last_resp  = resp_take && ((resp_cnt_q + 5'd1) == n_dwords);
  end

  assign inst_ready   = (state_q == SMEM_IDLE);
  assign sgpr_rd_addr = rd_addr_q;
  assign req_valid    = req_valid_q;
  assign req_addr     = req_addr_q;
  assign req_glc      = inst_q.glc;
  assign req_dlc      = inst_q.dlc;
  assign sgpr_wr_en   = resp_take;
  assign sgpr_wr_addr = resp_take ? (inst_q.sdata + {2'b00, resp_cnt_q}) : 7'd0;
  assign sgpr_wr_data = resp_take ? resp_data : 32'd0;
  assign done         = last_resp;
  assign err          = calc_err;

  // Control FSM: operand fetch, address calculation, issue and drain.
  // NOTE: non-blocking assignments keep every register update in this block
  // order-independent within the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SMEM_IDLE;
      inst_q      <= '0;
      base_q      <= '0;
      rd_addr_q   <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
    end else begin
      if (resp_take)
        resp_cnt_q <= resp_cnt_q + 5'd1;

      case (state_q)
        SMEM_IDLE: begin
          if (inst_valid) begin
            inst_q      <= smem_inst_in;
            rd_addr_q   <= {smem_inst_in.sbase, 1'b0};
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            state_q     <= SMEM_RD_LO;
          end
        end
        SMEM_RD_LO: begin
          rd_addr_q <= {inst_q.sbase, 1'b1};
          state_q   <= SMEM_RD_HI;
        end
        SMEM_RD_HI: begin
          base_q[31:0] <= sgpr_rd_data;
          rd_addr_q    <= inst_q.soffset;
          state_q      <= SMEM_RD_SOFF;
        end
        SMEM_RD_SOFF: begin
          base_q[63:32] <= sgpr_rd_data;
          state_q       <= SMEM_CALC;
        end
        SMEM_CALC: begin
          if (calc_err) begin
            state_q <= SMEM_IDLE;
          end else begin
            req_valid_q <= 1'b1;
            req_addr_q  <= calc_addr;
            state_q     <= SMEM_ISSUE;
          end
        end
        SMEM_ISSUE: begin
          if (req_hs) begin
            issue_cnt_q <= issue_cnt_q + 5'd1;
            if (last_issue) begin
              req_valid_q <= 1'b0;
              state_q     <= SMEM_DRAIN;
            end else begin
              req_addr_q <= req_addr_q + 64'd4;
            end
          end
          if (last_resp)
            state_q <= SMEM_IDLE;
        end
        SMEM_DRAIN: begin
          if (last_resp)
            state_q <= SMEM_IDLE;
        end
        default: state_q <= SMEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smem_request_unit.sv
// Bench for smem_request_unit: directed vector table, reset-abort sequence and
// randomized loads checked against an arithmetic model of the load semantics.
// Honors SMEM_SDATA_ALIGN_CHECK_EN the same way as the design.
module tb_smem_request_unit;
  import common_pkg::*;

  logic        clk;
  logic        reset;
  smem_inst_t  smem_inst_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [6:0]  sgpr_rd_addr;
  logic [31:0] sgpr_rd_data;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_glc;
  logic        req_dlc;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        sgpr_wr_en;
  logic [6:0]  sgpr_wr_addr;
  logic [31:0] sgpr_wr_data;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sgpr [128];

  smem_request_unit dut (
    .clk          (clk),
    .reset        (reset),
    .smem_inst_in (smem_inst_in),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .sgpr_rd_addr (sgpr_rd_addr),
    .sgpr_rd_data (sgpr_rd_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_glc      (req_glc),
    .req_dlc      (req_dlc),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .sgpr_wr_en   (sgpr_wr_en),
    .sgpr_wr_addr (sgpr_wr_addr),
    .sgpr_wr_data (sgpr_wr_data),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered SGPR read port: data follows the address by one cycle.
  always @(posedge clk) sgpr_rd_data <= sgpr[sgpr_rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_inst_ready"}, inst_ready, 1);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_req_glc"}, req_glc, 0);
    check({tag, "_req_dlc"}, req_dlc, 0);
    check({tag, "_rd_addr"}, sgpr_rd_addr, 0);
    check({tag, "_wr_en"}, sgpr_wr_en, 0);
    check({tag, "_wr_addr"}, sgpr_wr_addr, 0);
    check({tag, "_wr_data"}, sgpr_wr_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Reference: what a load should do, straight from the instruction semantics.
  function automatic void model(input smem_inst_t inst, output int n,
                                output logic [63:0] addr, output bit e);
    logic [63:0] base;
    logic [63:0] sum;
    longint      off;
    int          gran;
    n    = (inst.op <= 8'd4) ? (1 << inst.op) : 0;
    base = {sgpr[{inst.sbase, 1'b1}], sgpr[{inst.sbase, 1'b0}]};
    off  = inst.offset[20] ? (longint'(inst.offset) - 64'sd2097152) : longint'(inst.offset);
    sum  = base + off;
    if (inst.soffset != 7'd125) sum = sum + {32'd0, sgpr[inst.soffset]};
    addr = sum - (sum % 4);
    e    = (n == 0);
`ifdef SMEM_SDATA_ALIGN_CHECK_EN
    gran = (n < 4) ? n : 4;
    if (n != 0 && (int'(inst.sdata) % gran) != 0) e = 1'b1;
`else
    gran = 0;
`endif
  endfunction

  // Drive one instruction to completion and check every cycle against the
  // expected request/write stream. ready_mode: 0 always, 1 toggle, 2 random.
  task automatic run_load(input smem_inst_t inst, input int ready_mode,
                          input int exp_n, input logic [63:0] exp_addr, input bit exp_err);
    int   issued = 0;
    int   respd  = 0;
    int   pend   = 0;
    bit   fin    = 0;
    bit   exp_req;
    logic [6:0] exp_wa;
    @(negedge clk);
    smem_inst_in = inst;
    inst_valid   = 1'b1;
    #1 check("inst_ready_idle", inst_ready, 1);
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      inst_valid = 1'b0;
      req_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? c[0] : 1'($urandom_range(0, 1));
      resp_valid = (pend > 0) && ($urandom_range(0, 2) != 0);
      resp_data  = $urandom;
      #1;
      if (c == 1) check("rd_addr_lo", sgpr_rd_addr, {inst.sbase, 1'b0});
      if (c == 2) check("rd_addr_hi", sgpr_rd_addr, {inst.sbase, 1'b1});
      if (c == 3) check("rd_addr_soff", sgpr_rd_addr, inst.soffset);
      check("err", err, exp_err && c == 4);
      if (exp_err && c == 5) begin
        check("inst_ready_after_err", inst_ready, 1);
        check("req_valid_after_err", req_valid, 0);
        fin = 1;
      end else begin
        check("inst_ready_busy", inst_ready, 0);
        exp_req = !exp_err && c >= 5 && issued < exp_n;
        check("req_valid", req_valid, exp_req);
        if (exp_req) begin
          check("req_addr", req_addr, exp_addr + 64'(issued) * 64'd4);
          check("req_glc", req_glc, inst.glc);
          check("req_dlc", req_dlc, inst.dlc);
        end
        check("wr_en", sgpr_wr_en, resp_valid);
        if (resp_valid) begin
          exp_wa = inst.sdata + 7'(respd);
          check("wr_addr", sgpr_wr_addr, exp_wa);
          check("wr_data", sgpr_wr_data, resp_data);
        end
        check("done", done, resp_valid && (respd + 1 == exp_n));
        if (resp_valid) begin
          pend--;
          respd++;
          if (respd == exp_n) fin = 1;
        end
        if (exp_req && req_ready) begin
          issued++;
          pend++;
        end
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got issued=%0d written=%0d expected %0d", issued, respd, exp_n);
    end
    @(negedge clk);
    resp_valid = 1'b0;
    req_ready  = 1'b0;
    #1;
    check("inst_ready_after", inst_ready, 1);
    check("done_after", done, 0);
    check("wr_en_after", sgpr_wr_en, 0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [5:0]  sbase;
    logic [6:0]  sdata;
    logic [20:0] offset;
    logic [6:0]  soffset;
    logic        glc;
    logic        dlc;
    logic [63:0] base;
    logic [31:0] soffval;
    int          ready_mode;
    int          exp_n;
    logic [63:0] exp_addr;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    smem_inst_t inst;
    int         n;
    logic [63:0] a;
    bit         e;

    // Directed vectors: single dword, 16-dword toggled ready, negative offset
    // wrapping, illegal ops, destination alignment, sdata wrap with masking.
    vecs[0] = '{8'd0, 6'd2, 7'd10, 21'h10, 7'd125, 1'b0, 1'b0, 64'h1000, 32'd0, 0, 1, 64'h1010, 1'b0};
    vecs[1] = '{8'd4, 6'd3, 7'd16, 21'h0, 7'd20, 1'b1, 1'b0, 64'h1_2345_6700, 32'd8, 1, 16, 64'h1_2345_6708, 1'b0};
    vecs[2] = '{8'd1, 6'd8, 7'd2, 21'h1FFFFC, 7'd125, 1'b0, 1'b1, 64'h0, 32'd0, 2, 2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[3] = '{8'h09, 6'd1, 7'd0, 21'h0, 7'd125, 1'b0, 1'b0, 64'h500, 32'd0, 0, 0, 64'h0, 1'b1};
`ifdef SMEM_SDATA_ALIGN_CHECK_EN
    vecs[4] = '{8'd2, 6'd4, 7'd6, 21'h0, 7'd125, 1'b0, 1'b0, 64'h40, 32'd0, 0, 4, 64'h40, 1'b1};
`else
    vecs[4] = '{8'd2, 6'd4, 7'd6, 21'h0, 7'd125, 1'b0, 1'b0, 64'h40, 32'd0, 0, 4, 64'h40, 1'b0};
`endif
    vecs[5] = '{8'd3, 6'd5, 7'd124, 21'h2, 7'd30, 1'b1, 1'b1, 64'h2000, 32'd3, 2, 8, 64'h2004, 1'b0};
    vecs[6] = '{8'd5, 6'd7, 7'd0, 21'h0, 7'd125, 1'b0, 1'b0, 64'h900, 32'd0, 0, 0, 64'h0, 1'b1};

    for (int i = 0; i < 128; i++) sgpr[i] = $urandom;
    reset        = 1'b1;
    smem_inst_in = '0;
    inst_valid   = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_data    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("reset");

    for (int i = 0; i < 7; i++) begin
      sgpr[{vecs[i].sbase, 1'b0}] = vecs[i].base[31:0];
      sgpr[{vecs[i].sbase, 1'b1}] = vecs[i].base[63:32];
      sgpr[125] = 32'h0000_0777;
      if (vecs[i].soffset != 7'd125) sgpr[vecs[i].soffset] = vecs[i].soffval;
      inst = '{sbase: vecs[i].sbase, sdata: vecs[i].sdata, dlc: vecs[i].dlc, glc: vecs[i].glc,
               op: vecs[i].op, offset: vecs[i].offset, soffset: vecs[i].soffset};
      run_load(inst, vecs[i].ready_mode, vecs[i].exp_n, vecs[i].exp_addr, vecs[i].exp_err);
    end

    // Reset in DRAIN after 3 of 8 writes; later stray responses must be dropped.
    begin
      int issued = 0;
      sgpr[12] = 32'h3000;
      sgpr[13] = 32'h0;
      inst = '{sbase: 6'd6, sdata: 7'd40, dlc: 1'b1, glc: 1'b1, op: 8'd3, offset: 21'h0, soffset: 7'd125};
      @(negedge clk);
      smem_inst_in = inst;
      inst_valid   = 1'b1;
      for (int c = 1; c <= 40 && issued < 8; c++) begin
        @(negedge clk);
        inst_valid = 1'b0;
        req_ready  = 1'b1;
        #1;
        if (req_valid) issued++;
      end
      check("abort_issued", issued, 8);
      @(negedge clk);
      req_ready = 1'b0;
      #1 check("abort_req_valid_drain", req_valid, 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = $urandom;
        #1;
        check("abort_wr_en", sgpr_wr_en, 1);
        check("abort_wr_addr", sgpr_wr_addr, 7'd40 + 7'(k));
        check("abort_done", done, 0);
      end
      @(negedge clk);
      resp_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1 check_reset_vals("abort");
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = $urandom;
        #1;
        check("stray_wr_en", sgpr_wr_en, 0);
        check("stray_done", done, 0);
        check("stray_inst_ready", inst_ready, 1);
      end
      @(negedge clk);
      resp_valid = 1'b0;
    end

    // Randomized loads against the reference model.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 128; i++) sgpr[i] = $urandom;
      inst.sbase   = 6'($urandom);
      inst.sdata   = 7'($urandom);
      inst.dlc     = 1'($urandom);
      inst.glc     = 1'($urandom);
      inst.op      = 8'($urandom_range(0, 6));
      inst.offset  = 21'($urandom);
      inst.soffset = ($urandom_range(0, 3) == 0) ? 7'd125 : 7'($urandom);
      model(inst, n, a, e);
      run_load(inst, int'($urandom_range(0, 2)), n, a, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
